// File: rtl/csa_accum_seq.sv
// -----------------------------------------------------------------------------
// csa_accum_seq
//   Sequenced multi-operand accumulator built around one shared 3:2 compressor.
//   Operands stream in over a valid/ready port. Each accepted operand costs one
//   compressor pass into a carry-save (sum, carry) pair. At the end of a group
//   the pair is resolved with one carry-propagate add, and the result is then
//   offered on a valid/ready result port.
//
//   Build option: CSA_ACCUM_SIGNED_EN
//     defined   - op_i is two's complement, sign-extended; res_o is signed.
//     undefined - op_i is unsigned, zero-extended; res_o is unsigned.
//
// Ports
//   clk_i        clock, rising edge
//   rst_ni       asynchronous reset, active-low
//   op_i         operand (WIDTH_I bits)
//   op_valid_i   operand valid
//   op_last_i    operand closes the group (qualified by op_valid_i)
//   op_ready_o   operand accepted when op_valid_i & op_ready_o
//   res_o        resolved group sum (ACC_W bits)
//   res_valid_o  result valid (registered)
//   res_ready_i  result consumed when res_valid_o & res_ready_i
//   op_count_o   operands accepted in the current group
//   busy_o       FSM is not idle
// -----------------------------------------------------------------------------
module csa_accum_seq #(
    parameter  int unsigned WIDTH_I = 8,
    parameter  int unsigned N_OPS   = 4,
    localparam int unsigned ACC_W   = WIDTH_I + $clog2(N_OPS),
    localparam int unsigned CNT_W   = $clog2(N_OPS + 1)
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [WIDTH_I-1:0] op_i,
    input  logic               op_valid_i,
    input  logic               op_last_i,
    output logic               op_ready_o,
    output logic [ACC_W-1:0]   res_o,
    output logic               res_valid_o,
    input  logic               res_ready_i,
    output logic [CNT_W-1:0]   op_count_o,
    output logic               busy_o
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCUM   = 2'd1,
        RESOLVE = 2'd2,
        DONE    = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [ACC_W-1:0]   sum_q, sum_d;
    logic [ACC_W-1:0]   carry_q, carry_d;
    logic [ACC_W-1:0]   res_q, res_d;
    logic               res_valid_q, res_valid_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [ACC_W-1:0]   op_ext;
    logic [ACC_W-1:0]   csa_sum;
    logic [ACC_W-1:0]   csa_carry;
    logic [CNT_W-1:0]   cnt_inc;
    logic               op_ready;
    logic               accept;
    logic               last;

`ifdef CSA_ACCUM_SIGNED_EN
    assign op_ext = ACC_W'($signed(op_i));
`else
    assign op_ext = ACC_W'(op_i);
`endif

    // Shared 3:2 compressor: bitwise full adders; the majority (carry) vector
    // moves up one weight and its top bit falls off (mod 2^ACC_W).
    assign csa_sum   = sum_q ^ carry_q ^ op_ext;
    assign csa_carry = ((sum_q & carry_q) | (sum_q & op_ext) | (carry_q & op_ext)) << 1;

    // Ready depends on state only, so there is no valid->ready combinational path.
    assign op_ready = (state_q == IDLE) || (state_q == ACCUM);
    assign accept   = op_valid_i & op_ready;
    assign cnt_inc  = cnt_q + CNT_W'(1);
    // The group closes on op_last_i or when the operand limit is reached.
    assign last     = op_last_i | (cnt_inc == CNT_W'(N_OPS));

    always_comb begin
        state_d     = state_q;
        sum_d       = sum_q;
        carry_d     = carry_q;
        res_d       = res_q;
        res_valid_d = res_valid_q;
        cnt_d       = cnt_q;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    sum_d   = op_ext;
                    carry_d = '0;
                    cnt_d   = cnt_inc;
                    state_d = last ? RESOLVE : ACCUM;
                end
            end
            ACCUM: begin
                if (accept) begin
                    sum_d   = csa_sum;
                    carry_d = csa_carry;
                    cnt_d   = cnt_inc;
                    if (last) state_d = RESOLVE;
                end
            end
            RESOLVE: begin
                res_d       = sum_q + carry_q;
                res_valid_d = 1'b1;
                state_d     = DONE;
            end
            DONE: begin
                if (res_ready_i) begin
                    res_valid_d = 1'b0;
                    cnt_d       = '0;
                    sum_d       = '0;
                    carry_d     = '0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            sum_q       <= '0;
            carry_q     <= '0;
            res_q       <= '0;
            res_valid_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            sum_q       <= sum_d;
            carry_q     <= carry_d;
            res_q       <= res_d;
            res_valid_q <= res_valid_d;
            cnt_q       <= cnt_d;
        end
    end

    assign op_ready_o  = op_ready;
    assign res_o       = res_q;
    assign res_valid_o = res_valid_q;
    assign op_count_o  = cnt_q;
    assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_csa_accum_seq.sv
module tb_csa_accum_seq;

    localparam int unsigned WIDTH_I = 8;
    localparam int unsigned N_OPS   = 4;
    localparam int unsigned ACC_W   = 10;
    localparam int unsigned CNT_W   = 3;

    logic               clk;
    logic               rst_n;
    logic [WIDTH_I-1:0] op;
    logic               op_valid;
    logic               op_last;
    logic               op_ready;
    logic [ACC_W-1:0]   res;
    logic               res_valid;
    logic               res_ready;
    logic [CNT_W-1:0]   op_count;
    logic               busy;

    int errors = 0;
    int checks = 0;

    csa_accum_seq #(.WIDTH_I(WIDTH_I), .N_OPS(N_OPS)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .op_i       (op),
        .op_valid_i (op_valid),
        .op_last_i  (op_last),
        .op_ready_o (op_ready),
        .res_o      (res),
        .res_valid_o(res_valid),
        .res_ready_i(res_ready),
        .op_count_o (op_count),
        .busy_o     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string            name;
        int unsigned      n;
        logic [7:0]       ops  [4];
        logic             lasts[4];
        logic [ACC_W-1:0] exp_res;
        logic [CNT_W-1:0] exp_cnt;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Presents one operand at the falling edge and holds it until an accepting
    // rising edge; valid drops 1 time unit after that edge.
    task automatic send_op(input logic [7:0] v, input logic l);
        int unsigned waited = 0;
        @(negedge clk);
        op       = v;
        op_last  = l;
        op_valid = 1'b1;
        while (!op_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!op_ready) chk("op_ready_timeout", 0, 1);
        @(posedge clk);
        #1;
        op_valid = 1'b0;
        op_last  = 1'b0;
    endtask

    task automatic take_result(input string name, input logic [ACC_W-1:0] er,
                               input logic [CNT_W-1:0] ec);
        int unsigned waited = 0;
        @(negedge clk);
        while (!res_valid && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        chk({name, "_valid"}, res_valid, 1);
        chk({name, "_res"}, res, er);
        chk({name, "_cnt"}, op_count, ec);
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
        @(negedge clk);
        chk({name, "_idle_busy"}, busy, 0);
        chk({name, "_idle_cnt"}, op_count, 0);
    endtask

    initial begin
        rst_n     = 1'b0;
        op        = '0;
        op_valid  = 1'b0;
        op_last   = 1'b0;
        res_ready = 1'b0;

        vecs[0] = '{"seq3579", 4, '{8'd3, 8'd5, 8'd7, 8'd9}, '{0, 0, 0, 1}, 10'd24, 3'd4};
        vecs[1] = '{"single2a", 1, '{8'h2A, 8'd0, 8'd0, 8'd0}, '{1, 0, 0, 0}, 10'd42, 3'd1};
        vecs[2] = '{"max_forced", 4, '{8'd255, 8'd255, 8'd255, 8'd255}, '{0, 0, 0, 0}, 10'd1020, 3'd4};
        vecs[3] = '{"two_ops", 2, '{8'd100, 8'd200, 8'd0, 8'd0}, '{0, 1, 0, 0}, 10'd300, 3'd2};
        vecs[4] = '{"three_ops", 3, '{8'd1, 8'd2, 8'd3, 8'd0}, '{0, 0, 1, 0}, 10'd6, 3'd3};
`ifdef CSA_ACCUM_SIGNED_EN
        vecs[5] = '{"neg_ops", 3, '{8'hFF, 8'hFF, 8'h03, 8'd0}, '{0, 0, 1, 0}, 10'h001, 3'd3};
`else
        vecs[5] = '{"neg_ops", 3, '{8'hFF, 8'hFF, 8'h03, 8'd0}, '{0, 0, 1, 0}, 10'h201, 3'd3};
`endif

        #12;
        chk("rst_res", res, 0);
        chk("rst_valid", res_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cnt", op_count, 0);
        chk("rst_ready", op_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            for (int unsigned k = 0; k < vecs[i].n; k++)
                send_op(vecs[i].ops[k], vecs[i].lasts[k]);
            take_result(vecs[i].name, vecs[i].exp_res, vecs[i].exp_cnt);
        end

        // Latency: last operand accepted at edge t, RESOLVE after t, DONE after t+1.
        send_op(8'd10, 1'b0);
        send_op(8'd20, 1'b1);
        @(negedge clk);
        chk("lat_resolve_valid", res_valid, 0);
        chk("lat_resolve_ready", op_ready, 0);
        chk("lat_resolve_busy", busy, 1);
        @(negedge clk);
        chk("lat_done_valid", res_valid, 1);
        chk("lat_done_res", res, 30);

        // Result stall: 5 cycles without res_ready, with a pending operand offered.
        op       = 8'd77;
        op_last  = 1'b1;
        op_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("stall_valid", res_valid, 1);
            chk("stall_res", res, 30);
            chk("stall_cnt", op_count, 2);
            chk("stall_ready", op_ready, 0);
        end
        op_valid = 1'b0;
        op_last  = 1'b0;
        take_result("stall", 10'd30, 3'd2);

        // Forced close: a 5th operand held valid must not be taken.
        for (int k = 0; k < 4; k++) send_op(8'd255, 1'b0);
        op       = 8'd5;
        op_valid = 1'b1;
        @(negedge clk);
        chk("forced_ready_resolve", op_ready, 0);
        chk("forced_cnt_resolve", op_count, 4);
        @(negedge clk);
        chk("forced_ready_done", op_ready, 0);
        chk("forced_res", res, 1020);
        op_valid = 1'b0;
        take_result("forced", 10'd1020, 3'd4);

        // Reset mid-accumulation discards the group.
        send_op(8'd50, 1'b0);
        send_op(8'd60, 1'b0);
        @(negedge clk);
        chk("pre_rst_cnt", op_count, 2);
        rst_n = 1'b0;
        #2;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_cnt", op_count, 0);
        chk("mid_rst_valid", res_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        send_op(8'd1, 1'b0);
        send_op(8'd1, 1'b1);
        take_result("post_rst", 10'd2, 3'd2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

endmodule
